// File: rtl/screen_char_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module  : screen_pkg
// Brief   : Geometry, control codes and FSM encoding for the text character store.
// Rev     : 1.0  initial release
// ============================================================================
package screen_pkg;
   localparam int COLS = 70;
   localparam int ROWS = 30;

   localparam logic [7:0] BLANK_CH     = 8'h20;
   localparam logic [7:0] ASCII_CR     = 8'h0D;
   localparam logic [7:0] ASCII_BS     = 8'h08;
   localparam logic [7:0] ASCII_CURSOR = 8'h5F;

   localparam logic [6:0] COL_LAST   = 7'(COLS - 1);
   localparam logic [4:0] ROW_LAST   = 5'(ROWS - 1);
   localparam logic [4:0] ROW_PENULT = 5'(ROWS - 2);
   localparam logic [6:0] COL_LIMIT  = 7'(COLS);
   localparam logic [5:0] ROW_LIMIT  = 6'(ROWS);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CLEAR  = 2'd1,
      SCROLL = 2'd2,
      BLANK  = 2'd3
   } state_t;
endpackage
`default_nettype wire

// File: rtl/screen_char_buf_ram.sv
`default_nettype none
// ============================================================================
// Module  : screen_char_ram
// Brief   : 4096x8 character RAM, one write port, two synchronous read ports.
// Rev     : 1.0  initial release
// ============================================================================
module screen_char_ram (
   input  logic        clk,
   input  logic        we,
   input  logic [11:0] wr_addr,
   input  logic [7:0]  wr_data,
   input  logic [11:0] vga_addr,
   output logic [7:0]  vga_q,
   input  logic [11:0] scr_addr,
   output logic [7:0]  scr_q
);
   logic [7:0] r_mem [0:4095];

   always_ff @(posedge clk) begin
      if (we)
         r_mem[wr_addr] <= wr_data;
      vga_q <= r_mem[vga_addr];
      scr_q <= r_mem[scr_addr];
   end
endmodule
`default_nettype wire

// File: rtl/screen_char_buf.sv
`default_nettype none
// ============================================================================
// Module  : screen_char_buf
// Brief   : 70x30 text screen store with cursor, scroll and clear; VGA read port.
//           Optional cursor blink overlay: SCREEN_BUF_CURSOR_BLINK_EN.
// Rev     : 1.0  initial release
// ============================================================================
module screen_char_buf
   import screen_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] h_addr,
   input  logic [9:0] v_addr,
   output logic [7:0] cur_ascii,
   input  logic [7:0] in_ascii,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       clear,
   output logic       busy,
   output logic [6:0] cursor_col,
   output logic [4:0] cursor_row
);
   state_t      r_state;
   logic [6:0]  r_col;
   logic [4:0]  r_row;
   logic [6:0]  r_op_col;
   logic [4:0]  r_op_row;
   logic        r_rd_done;
   logic        r_wr_pend;
   logic [11:0] r_wr_addr;
   logic        r_oob;

   logic [6:0]  w_col;
   logic [5:0]  w_row;
   logic        w_accept;
   logic        w_printable;
   logic        w_row_adv;
   logic        w_we;
   logic [11:0] w_wr_addr;
   logic [7:0]  w_wr_data;
   logic [7:0]  w_vga_q;
   logic [7:0]  w_scr_q;

   assign w_col = 7'(h_addr / 10'd9);
   assign w_row = 6'(v_addr / 10'd16);

   assign in_ready    = (r_state == IDLE) && !clear;
   assign busy        = (r_state != IDLE);
   assign cursor_col  = r_col;
   assign cursor_row  = r_row;
   assign w_accept    = in_valid && in_ready;
   assign w_printable = (in_ascii >= 8'h20) && (in_ascii <= 8'h7E);
   assign w_row_adv   = w_accept && ((w_printable && (r_col == COL_LAST)) || (in_ascii == ASCII_CR));

   always_comb begin
      w_we      = 1'b0;
      w_wr_addr = {r_op_row, r_op_col};
      w_wr_data = BLANK_CH;
      case (r_state)
         IDLE: begin
            if (w_accept && w_printable) begin
               w_we      = 1'b1;
               w_wr_addr = {r_row, r_col};
               w_wr_data = in_ascii;
            end else if (w_accept && (in_ascii == ASCII_BS) && (r_col != 7'd0)) begin
               w_we      = 1'b1;
               w_wr_addr = {r_row, r_col - 7'd1};
            end
         end
         CLEAR:  w_we = 1'b1;
         SCROLL: begin
            // Data read from row r+1 last cycle lands one row up this cycle
            w_we      = r_wr_pend;
            w_wr_addr = r_wr_addr;
            w_wr_data = w_scr_q;
         end
         BLANK: begin
            w_we      = 1'b1;
            w_wr_addr = {ROW_LAST, r_op_col};
         end
         default: ;
      endcase
   end

   screen_char_ram u_ram (
      .clk      (clk),
      .we       (w_we),
      .wr_addr  (w_wr_addr),
      .wr_data  (w_wr_data),
      .vga_addr ({w_row[4:0], w_col}),
      .vga_q    (w_vga_q),
      .scr_addr ({r_op_row + 5'd1, r_op_col}),
      .scr_q    (w_scr_q)
   );

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_state   <= CLEAR;
         r_col     <= 7'd0;
         r_row     <= 5'd0;
         r_op_col  <= 7'd0;
         r_op_row  <= 5'd0;
         r_rd_done <= 1'b0;
         r_wr_pend <= 1'b0;
         r_wr_addr <= 12'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_row_adv) begin
                  r_col <= 7'd0;
                  if (r_row == ROW_LAST) begin
                     r_state   <= SCROLL;
                     r_op_col  <= 7'd0;
                     r_op_row  <= 5'd0;
                     r_rd_done <= 1'b0;
                  end else begin
                     r_row <= r_row + 5'd1;
                  end
               end else if (w_accept && w_printable) begin
                  r_col <= r_col + 7'd1;
               end else if (w_accept && (in_ascii == ASCII_BS) && (r_col != 7'd0)) begin
                  r_col <= r_col - 7'd1;
               end
            end
            CLEAR: begin
               if (r_op_col == COL_LAST) begin
                  r_op_col <= 7'd0;
                  if (r_op_row == ROW_LAST) begin
                     r_op_row <= 5'd0;
                     r_state  <= IDLE;
                     r_col    <= 7'd0;
                     r_row    <= 5'd0;
                  end else begin
                     r_op_row <= r_op_row + 5'd1;
                  end
               end else begin
                  r_op_col <= r_op_col + 7'd1;
               end
            end
            SCROLL: begin
               if (!r_rd_done) begin
                  r_wr_pend <= 1'b1;
                  r_wr_addr <= {r_op_row, r_op_col};
                  if (r_op_col == COL_LAST) begin
                     r_op_col <= 7'd0;
                     if (r_op_row == ROW_PENULT) begin
                        r_op_row  <= 5'd0;
                        r_rd_done <= 1'b1;
                     end else begin
                        r_op_row <= r_op_row + 5'd1;
                     end
                  end else begin
                     r_op_col <= r_op_col + 7'd1;
                  end
               end else begin
                  // Flush cycle: final pending write retires here
                  r_wr_pend <= 1'b0;
                  r_rd_done <= 1'b0;
                  r_state   <= BLANK;
               end
            end
            BLANK: begin
               if (r_op_col == COL_LAST) begin
                  r_op_col <= 7'd0;
                  r_state  <= IDLE;
               end else begin
                  r_op_col <= r_op_col + 7'd1;
               end
            end
            default: r_state <= CLEAR;
         endcase
      end
   end

   // Out-of-range flag resets high so cur_ascii reads 0 straight out of reset
   always_ff @(posedge clk) begin
      if (rst)
         r_oob <= 1'b1;
      else
         r_oob <= (w_col >= COL_LIMIT) || (w_row >= ROW_LIMIT);
   end

`ifdef SCREEN_BUF_CURSOR_BLINK_EN
   logic [5:0] r_frame;
   logic       r_hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame <= 6'd0;
         r_hit   <= 1'b0;
      end else begin
         if ((h_addr == 10'd0) && (v_addr == 10'd0))
            r_frame <= r_frame + 6'd1;
         r_hit <= (w_col == r_col) && (w_row == {1'b0, r_row});
      end
   end

   assign cur_ascii = r_oob ? 8'h00 : ((r_hit && r_frame[5]) ? ASCII_CURSOR : w_vga_q);
`else
   assign cur_ascii = r_oob ? 8'h00 : w_vga_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_screen_char_buf.sv
`default_nettype none
// ============================================================================
// Module  : tb_screen_char_buf
// Brief   : Scoreboard bench for screen_char_buf against a 2-D array screen model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_screen_char_buf;
   localparam int NC = 70;
   localparam int NR = 30;
   localparam int K_CHAR = 0, K_CUR = 1, K_BUSY = 2, K_READY = 3, K_RUN = 4, K_TMO = 5;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] h_addr, v_addr;
   logic [7:0] cur_ascii;
   logic [7:0] in_ascii;
   logic       in_valid;
   logic       in_ready;
   logic       clear;
   logic       busy;
   logic [6:0] cursor_col;
   logic [4:0] cursor_row;

   screen_char_buf dut (
      .clk(clk), .rst(rst), .h_addr(h_addr), .v_addr(v_addr), .cur_ascii(cur_ascii),
      .in_ascii(in_ascii), .in_valid(in_valid), .in_ready(in_ready), .clear(clear),
      .busy(busy), .cursor_col(cursor_col), .cursor_row(cursor_row)
   );

   always #5 clk = ~clk;

   typedef struct { int kind; int want; int h; int v; } exp_t;
   exp_t sb[$];

   int vectors = 0;
   int miscompares = 0;
   int timeouts = 0;
   int run_len = 0;
   int last_run = 0;
   logic probe = 1'b0;
   logic probe_d = 1'b0;

   logic [7:0] scr [0:NR-1][0:NC-1];
   int cx, cy;

   function automatic string kname(input int k);
      case (k)
         K_CHAR:  return "cur_ascii";
         K_CUR:   return "cursor";
         K_BUSY:  return "busy";
         K_READY: return "in_ready";
         K_RUN:   return "busy_cycles";
         default: return "wait_timeouts";
      endcase
   endfunction

   always @(posedge clk) probe_d <= probe;

   always @(negedge clk) begin
      if (rst)
         run_len <= 0;
      else if (busy)
         run_len <= run_len + 1;
      else if (run_len != 0) begin
         last_run <= run_len;
         run_len  <= 0;
      end
   end

   always @(negedge clk) begin : p_mon
      exp_t e;
      int   act;
      if (probe_d) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty actual=0 required=1");
         end else begin
            e = sb.pop_front();
            case (e.kind)
               K_CHAR:  act = int'(cur_ascii);
               K_CUR:   act = int'({cursor_col, cursor_row});
               K_BUSY:  act = int'(busy);
               K_READY: act = int'(in_ready);
               K_RUN:   act = last_run;
               default: act = timeouts;
            endcase
            if (act != e.want) begin
               miscompares++;
               $display("FAIL %s h=%0d v=%0d actual=0x%0h required=0x%0h",
                        kname(e.kind), e.h, e.v, act, e.want);
            end
         end
      end
   end

   // ---------------- reference model ----------------
   function automatic void model_clear();
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++)
            scr[r][c] = 8'h20;
      cx = 0;
      cy = 0;
   endfunction

   function automatic bit model_apply(input logic [7:0] ch);
      bit nl = 1'b0;
      if (ch >= 8'h20 && ch <= 8'h7E) begin
         scr[cy][cx] = ch;
         cx++;
         if (cx == NC) begin cx = 0; nl = 1'b1; end
      end else if (ch == 8'h0D) begin
         cx = 0;
         nl = 1'b1;
      end else if (ch == 8'h08 && cx > 0) begin
         cx--;
         scr[cy][cx] = 8'h20;
      end
      if (nl) begin
         if (cy < NR - 1) cy++;
         else begin
            for (int r = 0; r < NR - 1; r++)
               for (int c = 0; c < NC; c++)
                  scr[r][c] = scr[r+1][c];
            for (int c = 0; c < NC; c++)
               scr[NR-1][c] = 8'h20;
            return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   function automatic int model_at(input int h, input int v);
      int c = h / 9;
      int r = v / 16;
      if (c >= NC || r >= NR) return 0;
      return int'(scr[r][c]);
   endfunction

   // ---------------- stimulus ----------------
   task automatic issue(input int kind, input int want, input int h, input int v);
      exp_t e;
      e.kind = kind; e.want = want; e.h = h; e.v = v;
      h_addr = 10'(h);
      v_addr = 10'(v);
      probe  = 1'b1;
      sb.push_back(e);
      @(posedge clk); #1;
      probe = 1'b0;
   endtask

   task automatic probe_cell(input int h, input int v);
      issue(K_CHAR, model_at(h, v), h, v);
   endtask

   task automatic probe_cursor();
      issue(K_CUR, cx * 32 + cy, 0, 0);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin @(posedge clk); #1; n++; end
      if (busy) timeouts++;
   endtask

   task automatic send(input logic [7:0] ch, output bit scrolled);
      int n = 0;
      while (!in_ready && n < 5000) begin @(posedge clk); #1; n++; end
      if (!in_ready) timeouts++;
      in_valid = 1'b1;
      in_ascii = ch;
      @(posedge clk); #1;
      in_valid = 1'b0;
      scrolled = model_apply(ch);
   endtask

   task automatic send_chk(input logic [7:0] ch);
      bit s;
      send(ch, s);
      if (s) begin
         wait_idle(3000);
         issue(K_RUN, 2101, 0, 0);
         probe_cursor();
      end
   endtask

   task automatic scan_screen();
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++)
            probe_cell(c * 9 + int'($urandom_range(0, 8)), r * 16 + int'($urandom_range(0, 15)));
   endtask

   initial begin : p_stim
      bit s;
      logic [7:0] ch;
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_ascii = 8'h00;
      h_addr = 10'd639; v_addr = 10'd0;
      model_clear();
      @(posedge clk); #1;
      rst = 1'b0;

      issue(K_BUSY, 1, 639, 0);
      issue(K_READY, 0, 639, 0);
      issue(K_CUR, 0, 639, 0);
      issue(K_CHAR, 0, 639, 0);
      wait_idle(3000);
      issue(K_RUN, 2100, 0, 0);
      issue(K_READY, 1, 0, 0);
      probe_cursor();
      scan_screen();

      send_chk(8'h41);
      send_chk(8'h42);
      probe_cell(0, 0);
      probe_cell(9, 0);
      probe_cursor();
      send_chk(8'h08);
      probe_cursor();
      probe_cell(9, 0);

      for (int i = 0; i < 3; i++) send_chk(8'h0D);
      for (int i = 0; i < 5; i++) send_chk(8'(32 + $urandom_range(0, 94)));
      probe_cursor();
      send_chk(8'h0D);
      probe_cursor();
      send_chk(8'h08);
      probe_cursor();

      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 9))
            0: ch = 8'h0D;
            1: ch = 8'h08;
            2: ch = 8'($urandom_range(0, 31)) | 8'($urandom_range(0, 1) << 7);
            default: ch = 8'(32 + $urandom_range(0, 94));
         endcase
         send_chk(ch);
         if (i % 25 == 0) probe_cursor();
      end
      scan_screen();

      while (!(cx == NC - 1 && cy == NR - 1))
         send_chk(8'(32 + $urandom_range(0, 94)));
      probe_cursor();
      send_chk(8'h5A);
      scan_screen();

      send_chk(8'h78);
      send(8'h0D, s);
      repeat (499) @(posedge clk);
      #1;
      clear = 1'b1; in_valid = 1'b1; in_ascii = 8'h51;
      @(posedge clk); #1;
      clear = 1'b0; in_valid = 1'b0;
      model_clear();
      issue(K_BUSY, 1, 0, 0);
      wait_idle(3000);
      issue(K_RUN, 2600, 0, 0);
      probe_cursor();
      scan_screen();

      send_chk(8'h4B);
      clear = 1'b1; in_valid = 1'b1; in_ascii = 8'h4D;
      @(posedge clk); #1;
      clear = 1'b0; in_valid = 1'b0;
      model_clear();
      wait_idle(3000);
      issue(K_RUN, 2100, 0, 0);
      probe_cursor();
      probe_cell(0, 0);
      probe_cell(9, 0);

      send_chk(8'h31);
      probe_cell(639, 0);
      probe_cell(0, 480);
      probe_cell(630, 100);
      probe_cell(629, 479);
      probe_cell(0, 0);
      for (int i = 0; i < 60; i++)
         probe_cell(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));

      issue(K_TMO, 0, 0, 0);
      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin : p_watchdog
      #3000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "simulation time limit");
   end
endmodule
`default_nettype wire
